// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one shared memory bus between the fetch unit and the
// mem stage. At most one bus transaction is outstanding at a time. The mem stage
// normally wins a tie. A streak counter stops it from starving fetch: once it
// reaches STARVE_LIMIT consecutive wins while fetch waits, fetch gets the bus.
//
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to enable the bus timeout.
// When enabled, a busy phase that sees no bus_ack for TIMEOUT_CYCLES cycles is
// closed with a one-cycle bus_err pulse and a synthetic ack.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   fe_req/fe_addr/fe_flush      fetch request, address, PC redirect
//   fe_ack/fe_data               fetch response (same cycle as bus_ack)
//   ms_req/ms_wen/ms_addr/
//   ms_wdata/ms_wmask            mem-stage request
//   ms_ack/ms_rdata              mem-stage response (same cycle as bus_ack)
//   bus_req/bus_wen/bus_addr/
//   bus_wdata/bus_wmask          bus request, driven from registered grant values
//   bus_ack/bus_rdata            bus response
//   bus_err                      one-cycle timeout pulse (0 when timeout disabled)
//
// state   | meaning
// IDLE    | no transaction outstanding, arbitration happens here
// FE_BUSY | fetch access on the bus, waiting for bus_ack
// MS_BUSY | mem-stage access on the bus, waiting for bus_ack
module mem_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fe_req,
    input  logic [31:0] fe_addr,
    input  logic        fe_flush,
    output logic        fe_ack,
    output logic [31:0] fe_data,
    input  logic        ms_req,
    input  logic        ms_wen,
    input  logic [31:0] ms_addr,
    input  logic [31:0] ms_wdata,
    input  logic [3:0]  ms_wmask,
    output logic        ms_ack,
    output logic [31:0] ms_rdata,
    output logic        bus_req,
    output logic        bus_wen,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wmask,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_err
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FE_BUSY = 2'd1,
        MS_BUSY = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] streak, streak_nxt;
    logic          discard, discard_nxt;
    logic          grant_fe, grant_ms;
    logic          timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            streak    <= '0;
            discard   <= 1'b0;
            bus_addr  <= '0;
            bus_wen   <= 1'b0;
            bus_wdata <= '0;
            bus_wmask <= '0;
        end else begin
            state   <= state_nxt;
            streak  <= streak_nxt;
            discard <= discard_nxt;
            if (grant_fe) begin
                bus_addr  <= fe_addr;
                bus_wen   <= 1'b0;
                bus_wdata <= '0;
                bus_wmask <= 4'hF;
            end else if (grant_ms) begin
                bus_addr  <= ms_addr;
                bus_wen   <= ms_wen;
                bus_wdata <= ms_wdata;
                bus_wmask <= ms_wmask;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        streak_nxt  = streak;
        discard_nxt = discard;
        grant_fe    = 1'b0;
        grant_ms    = 1'b0;
        fe_ack      = 1'b0;
        ms_ack      = 1'b0;
        fe_data     = bus_rdata;
        ms_rdata    = bus_rdata;

        case (state)
            IDLE: begin
                // Mem stage wins ties until it has starved fetch STARVE_LIMIT times.
                if (fe_req && ms_req) begin
                    if (streak == STREAK_MAX) grant_fe = 1'b1;
                    else                      grant_ms = 1'b1;
                end else if (fe_req) begin
                    grant_fe = 1'b1;
                end else if (ms_req) begin
                    grant_ms = 1'b1;
                end

                if (grant_fe) begin
                    state_nxt   = FE_BUSY;
                    streak_nxt  = '0;
                    discard_nxt = 1'b0;
                end else if (grant_ms) begin
                    state_nxt = MS_BUSY;
                    if (!fe_req)                  streak_nxt = '0;
                    else if (streak != STREAK_MAX) streak_nxt = streak + 1'b1;
                end
            end

            FE_BUSY: begin
                if (bus_ack || timeout) begin
                    // A redirect seen at any point during the access, including
                    // the completing cycle, drops the stale instruction.
                    fe_ack      = !(discard || fe_flush);
                    state_nxt   = IDLE;
                    discard_nxt = 1'b0;
                    if (timeout) fe_data = 32'h0000_0013;
                end else if (fe_flush) begin
                    discard_nxt = 1'b1;
                end
            end

            MS_BUSY: begin
                if (bus_ack || timeout) begin
                    ms_ack    = 1'b1;
                    state_nxt = IDLE;
                    if (timeout) ms_rdata = 32'h0;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign bus_req = (state != IDLE);
    assign bus_err = timeout;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    // Down-counter loaded at grant; reaching zero in a busy cycle without
    // bus_ack marks the TIMEOUT_CYCLES-th busy cycle.
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (grant_fe || grant_ms) begin
            tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
        end else if (state != IDLE && tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    assign timeout = (state != IDLE) && (tmo_cnt == '0) && !bus_ack;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive mem-stage grants while fetch is pending.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: bus wait limit, used only under REQ-027.
REQ-003 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have fetch port fe_req in 1, fe_addr in 32, fe_flush in 1 (PC redirect), fe_ack out 1, fe_data out 32.
REQ-006 SHALL have mem-stage port ms_req in 1, ms_wen in 1, ms_addr in 32, ms_wdata in 32, ms_wmask in 4, ms_ack out 1, ms_rdata out 32.
REQ-007 SHALL have bus port bus_req out 1, bus_wen out 1, bus_addr out 32, bus_wdata out 32, bus_wmask out 4, bus_ack in 1, bus_rdata in 32.
REQ-008 SHALL have bus_err  output  1  one-cycle timeout pulse; tied 0 when REQ-027 is compiled out.

Function
REQ-009 SHALL implement three states: IDLE, FE_BUSY, MS_BUSY.
REQ-010 IDLE with only fe_req -> FE_BUSY; only ms_req -> MS_BUSY; neither -> stay IDLE.
REQ-011 IDLE with both requests -> MS_BUSY, unless streak counter equals STARVE_LIMIT, then FE_BUSY.
REQ-012 Streak counter: +1 per MS grant while fe_req high; cleared on any FE grant or when fe_req low at the grant decision; saturates at STARVE_LIMIT.
REQ-013 On the grant edge, SHALL register addr, wen, wdata and wmask of the winner (fetch: wen=0, wmask=4'hF); bus_* SHALL drive only these registered values.
REQ-014 bus_req SHALL be 1 exactly while in FE_BUSY or MS_BUSY; first bus_req cycle is the cycle after the request is seen in IDLE.
REQ-015 bus_ack in FE_BUSY SHALL produce fe_ack=1 in the same cycle with fe_data=bus_rdata; next state IDLE.
REQ-016 bus_ack in MS_BUSY SHALL produce ms_ack=1 in the same cycle with ms_rdata=bus_rdata; next state IDLE.
REQ-017 Back-to-back transactions SHALL have one IDLE cycle between bus_ack and the next bus_req (minimum 2-cycle cadence).
REQ-018 fe_flush in FE_BUSY SHALL set a discard flag; the in-flight access SHALL still complete on the bus, but fe_ack SHALL be 0 for it.
REQ-019 fe_flush coincident with bus_ack in FE_BUSY SHALL suppress that fe_ack.
REQ-020 fe_flush in IDLE or MS_BUSY SHALL have no effect; a fetch arriving with fe_flush in IDLE SHALL be granted normally.
REQ-021 fe_req or ms_req dropping while its transaction is in flight SHALL NOT abort it; response is delivered per REQ-015/016.
REQ-022 fe_ack and ms_ack SHALL never be 1 in the same cycle; at most one bus transaction outstanding.
REQ-023 bus_ack in IDLE SHALL be ignored.

Reset
REQ-024 reset_n low SHALL immediately force state IDLE, bus_req=0, fe_ack=0, ms_ack=0, bus_err=0, streak=0, discard=0, timeout count=0, registered bus_addr/wdata=0, bus_wmask=0, bus_wen=0.
REQ-025 Reset during FE_BUSY or MS_BUSY SHALL abandon the transaction; no ack SHALL be generated after release.
REQ-026 First grant after reset release SHALL follow REQ-010/011 with streak=0.

Configuration
REQ-027 With MEM_ARBITER_TIMEOUT_EN defined: a counter runs in FE_BUSY/MS_BUSY; after TIMEOUT_CYCLES cycles without bus_ack, bus_err=1 for one cycle, the requester's ack=1 with rdata=32'h00000013 (fetch) or 32'h0 (mem), state to IDLE. Without the macro: no counter, bus_err=0, waits indefinitely.

Verification
REQ-028 Fetch only: fe_req=1, fe_addr=32'h80000000, bus_ack 2 cycles after bus_req, bus_rdata=32'h00000093 -> bus_addr=32'h80000000, bus_wen=0, fe_ack=1 with fe_data=32'h00000093 in that cycle.
REQ-029 Contention: fe_req and ms_req held, bus_ack every bus cycle, STARVE_LIMIT=4 -> grant order MS,MS,MS,MS,FE,MS...; never two acks in one cycle.
REQ-030 Flush: FE_BUSY at 32'h80000004, fe_flush pulsed, bus_ack 3 cycles later -> fe_ack stays 0; next fetch at 32'h80000100 acked normally.
REQ-031 Store: ms_req=1, ms_wen=1, ms_addr=32'h80001000, ms_wdata=32'hDEADBEEF, ms_wmask=4'b0011 -> identical bus_* values; ms_ack with bus_ack.
REQ-032 Reset mid MS_BUSY: reset_n low 1 cycle -> bus_req=0 asynchronously; late bus_ack yields no ms_ack.
REQ-033 Timeout (macro on, TIMEOUT_CYCLES=8): bus_ack never asserted -> after 8 busy cycles bus_err=1, ms_ack=1, ms_rdata=0; macro off -> stays MS_BUSY.
